// File: rtl/ixc_assign_pkg.sv
// Purpose: shared types and sizing helpers for the elastic assign pipe.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ixc_assign_pkg;

   // Deepest retiming chain the block is built and characterised for.
   localparam int MAX_DEPTH = 8;

   // PASS is the combinational cell, PIPE is the registered slice chain.
   typedef enum logic {
      IXC_PASS,
      IXC_PIPE
   } ixc_assign_mode_e;

   // Occupancy counter width: enough bits for 0..depth, never narrower than 1.
   function automatic int cnt_w(input int depth);
      int w;
      w = $clog2(depth + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Build mode follows directly from the slice count.
   function automatic ixc_assign_mode_e mode_of(input int depth);
      return (depth == 0) ? IXC_PASS : IXC_PIPE;
   endfunction

endpackage

// File: rtl/ixc_assign_stage.sv
// Purpose: one register slice (valid bit + WIDTH data) of the assign pipe.
// Latency: 1 cycle from load to output.
// Backpressure: holds its beat while load is low; load comes from the ready chain.
module ixc_assign_stage
   import ixc_assign_pkg::*;
#(
   parameter int               WIDTH     = 296,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Valid bit: flush empties the slice; otherwise it takes the upstream
   // valid whenever the slice is allowed to load (empty or being drained).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= in_valid;
      end
   end

   // Data register moves only on a real transfer, so held data never wobbles
   // while the slice is stalled or empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= RESET_VAL;
      end else if (load && in_valid && !flush) begin
         data <= in_data;
      end
   end

endmodule

// File: rtl/ixc_assign_pipe.sv
// Purpose: elastic WIDTH-bit R->L assign net retimed through DEPTH slices.
// Latency: DEPTH cycles (0 = combinational pass-through).
// Backpressure: ready ripples combinationally from L_ready to R_ready, no skid.
module ixc_assign_pipe
   import ixc_assign_pkg::*;
#(
   parameter int               WIDTH     = 296,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      R_valid,
   output logic                      R_ready,
   input  logic [WIDTH-1:0]          R,
   output logic                      L_valid,
   input  logic                      L_ready,
   output logic [WIDTH-1:0]          L,
   output logic [cnt_w(DEPTH)-1:0]   occupancy
);

   localparam int               CW   = cnt_w(DEPTH);
   localparam ixc_assign_mode_e MODE = mode_of(DEPTH);

   if (MODE == IXC_PASS) begin : g_pass
      // Bit-exact with the original fixed cell: wires only, flush ignored.
      logic unused_pass;
      assign unused_pass = clk ^ rst ^ flush;
      assign L         = R;
      assign L_valid   = R_valid;
      assign R_ready   = L_ready;
      assign occupancy = '0;
   end else begin : g_pipe
      logic [DEPTH-1:0] v;
      logic [WIDTH-1:0] d    [DEPTH];
      logic [DEPTH-1:0] in_v;
      logic [WIDTH-1:0] in_d [DEPTH];
      logic [DEPTH:0]   rdy;

      // Ready chain: slice k may load when empty or when the slice (or L)
      // downstream takes its beat this cycle; evaluated output side first.
      always_comb begin
         rdy        = '0;
         rdy[DEPTH] = L_ready;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = !v[k] | rdy[k+1];
         end
      end

      // No upstream acceptance during reset or while the chain is being flushed.
      assign R_ready = rdy[0] & !flush & !rst;

      for (genvar k = 0; k < DEPTH; k++) begin : g_slice
         if (k == 0) begin : g_head
            assign in_v[k] = R_valid & R_ready;
            assign in_d[k] = R;
         end else begin : g_body
            assign in_v[k] = v[k-1];
            assign in_d[k] = d[k-1];
         end

         ixc_assign_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .load     (rdy[k]),
            .in_valid (in_v[k]),
            .in_data  (in_d[k]),
            .valid    (v[k]),
            .data     (d[k])
         );
      end

      // Output side: stale data is masked so L reads RESET_VAL when idle.
      assign L_valid = v[DEPTH-1];
      assign L       = v[DEPTH-1] ? d[DEPTH-1] : RESET_VAL;

      // Occupancy is the count of full slices.
      always_comb begin
         occupancy = '0;
         for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + CW'(v[k]);
         end
      end
   end

endmodule

// File: doc/ixc_assign_pipe.md
Name: ixc_assign_pipe

Overview:
- Parametrised, elastic successor to the fixed-width bitwise assign cell. Carries a WIDTH-bit bus from R to L through DEPTH register slices with a valid/ready handshake.
- Used where IXCOM-partitioned assign nets cross timing or board boundaries and need retiming without losing data under backpressure.
- Adds flush, occupancy reporting and a DEPTH=0 combinational mode that is bit-exact with the original cell.

Parameters:
- WIDTH, 296, data bits carried R to L; legal 1..4096.
- DEPTH, 2, register slices; 0 = pure combinational pass-through; legal 0..8.
- RESET_VAL, '0, value L shows while no beat is held (also the reset value of every data register).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  synchronous drop of all held beats.
- R_valid  in  1  upstream beat present.
- R_ready  out  1  block accepts beat this cycle.
- R  in  WIDTH  upstream data.
- L_valid  out  1  downstream beat present.
- L_ready  in  1  downstream accepts.
- L  out  WIDTH  downstream data.
- occupancy  out  $clog2(DEPTH+1) (min 1)  beats currently held, 0..DEPTH.

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - All stage valids = 0, data = RESET_VAL, occupancy = 0, L_valid = 0, L = RESET_VAL.
  - R_ready = 0 while rst is high, 1 in the first cycle after release.
- Transfer occurs on a cycle where valid & ready are both high at an interface.
- Stage k (0 = input side, DEPTH-1 = output side) holds {v_k, d_k}.
- Stage k may load when !v_k or when stage k+1 (or L) takes its beat the same cycle. Ready ripples combinationally from L_ready back to R_ready (no skid buffer). Full throughput: one beat per cycle when L_ready stays high.
- Latency: a beat accepted at cycle n appears on L with L_valid at n+DEPTH, given no backpressure.
- Ordering: strict FIFO. No beat is duplicated or dropped except by flush or rst.
- Output: L_valid = v_{DEPTH-1}; L = d_{DEPTH-1} when valid, else RESET_VAL. Data registers load only on an accepted transfer.
- occupancy = popcount of stage valids, updated each cycle. Reaches DEPTH only when every slice is full.
- Backpressure: with L_ready low and all stages full, R_ready = 0. Held data stays stable, so L does not change while L_valid & !L_ready (required protocol property).
- Upstream protocol: R_valid must not drop before its beat is accepted. R must stay stable while R_valid & !R_ready. Violations are undefined; the bench flags them.
- flush:
  - Next edge clears all v_k and sets occupancy = 0.
  - R_ready = 0 and L_valid is still driven during the flush cycle. A downstream take in that cycle counts as delivered; an upstream beat is not accepted.
- Simultaneous flush and rst: rst wins.
- rst asserted mid-transfer: immediate clear. Beats in flight are lost, and the bench expects this.
- DEPTH=0: L = R, L_valid = R_valid, R_ready = L_ready, occupancy = 0. flush is ignored. No registers are inferred.
- WIDTH=1 and DEPTH=1 are corner builds and must elaborate cleanly.

Decomposition:
- Package ixc_assign_pkg:
  - function cnt_w(depth) returning max(1,$clog2(depth+1)).
  - localparam MAX_DEPTH = 8.
  - typedef enum {IXC_PASS, IXC_PIPE} ixc_assign_mode_e, selected from DEPTH.
- Sub-module ixc_assign_stage: one slice holding valid and WIDTH data with async rst, flush and load enable. It is instantiated DEPTH times in a generate chain.
- Top module: the ready chain, the occupancy popcount, and the DEPTH=0 bypass.

Test Plan:
- Streaming, WIDTH=296, DEPTH=2: R_valid=1 and L_ready=1 constant, R = 0x1, 0x2, ... 0x10 on consecutive cycles -> L_valid first high 2 cycles after first accept; L = 0x1..0x10 in order, one per cycle; occupancy steady at 2.
- Backpressure: fill with 0xAA, 0xBB, then L_ready=0 for 5 cycles -> occupancy=2, R_ready=0, L stable at 0xAA. Release -> 0xAA then 0xBB, then a new beat 0xCC accepted the same cycle 0xAA leaves.
- Flush: occupancy=2, pulse flush with L_ready=0 -> next cycle occupancy=0, L_valid=0, L=RESET_VAL; R_ready=0 in the flush cycle, then 1.
- Async reset mid-stream: assert rst between edges with 2 beats held -> L_valid=0 and L=RESET_VAL immediately, without waiting for clk; after release the first new beat 0x55 emerges after 2 cycles.
- DEPTH=0 build, WIDTH=296: random R/R_valid/L_ready for 1000 cycles -> L==R, L_valid==R_valid, R_ready==L_ready every cycle, occupancy=0.
- DEPTH=8, WIDTH=1: random valid/ready (50%) for 10k beats -> scoreboard shows in-order, lossless data; occupancy never exceeds 8 and matches the model each cycle.
